// File: rtl/ramp_pkg.sv
// Shared types for the single-slope ADC test ramp.
// Holds the ramp controller state encoding.
package ramp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SWEEP
  } ramp_state_t;

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with period-wrap flag.
// Output is a registered compare against the duty code.
module pwm_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  assign wrap    = (cnt_q == '1);
  assign pwm_out = pwm_q;

  // next counter value and PWM compare
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    pwm_d = (cnt_q < duty);
  end

  // counter and PWM output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

endmodule

// File: rtl/ramp_generator.sv
// Monotonic code ramp for the single-slope ADC.
// Steps change only on PWM period boundaries.
module ramp_generator
  import ramp_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STEP_PERIODS  = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pwm_out,
  output logic [WIDTH-1:0] r2r_out,
  output logic [WIDTH-1:0] current_duty_cycle,
  output logic             sweep_active,
  output logic             sweep_done
);

  localparam int SETW = $clog2(SETTLE_CYCLES) + 1;
  localparam int STPW = $clog2(STEP_PERIODS) + 1;

  localparam logic [SETW-1:0] SETTLE_LOAD = SETW'(SETTLE_CYCLES - 1);
  localparam logic [STPW-1:0] STEP_LAST   = STPW'(STEP_PERIODS - 1);
  localparam logic [WIDTH-1:0] DUTY_MAX   = '1;

  ramp_state_t      state_q, state_d;
  logic [SETW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [STPW-1:0]  step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             done_q, done_d;
  logic             wrap;

  pwm_core #(
    .WIDTH(WIDTH)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty_q),
    .pwm_out(pwm_out),
    .wrap   (wrap)
  );

  assign r2r_out            = duty_q;
  assign current_duty_cycle = duty_q;
  assign sweep_active       = (state_q == SWEEP);
  assign sweep_done         = done_q;

  // next state, counters and duty; abort beats completion
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    step_cnt_d   = step_cnt_q;
    duty_d       = duty_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (enable) begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        duty_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else begin
          if (settle_cnt_q != '0)
            settle_cnt_d = settle_cnt_q - 1'b1;
          if (settle_cnt_q == '0 && wrap) begin
            state_d    = SWEEP;
            step_cnt_d = '0;
          end
        end
      end
      SWEEP: begin
        if (!enable) begin
          state_d    = IDLE;
          duty_d     = '0;
          step_cnt_d = '0;
        end else if (wrap) begin
          if (step_cnt_q != STEP_LAST) begin
            step_cnt_d = step_cnt_q + 1'b1;
          end else begin
            step_cnt_d = '0;
            if (duty_q != DUTY_MAX) begin
              duty_d = duty_q + 1'b1;
            end else begin
              done_d       = 1'b1;
              duty_d       = '0;
              state_d      = SETTLE;
              settle_cnt_d = SETTLE_LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // controller registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      step_cnt_q   <= '0;
      duty_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      step_cnt_q   <= step_cnt_d;
      duty_q       <= duty_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_ramp_generator.sv
// Directed bench for ramp_generator.
// WIDTH=4, STEP_PERIODS=2, SETTLE_CYCLES=3.
module tb_ramp_generator;

  localparam int W  = 4;
  localparam int SP = 2;
  localparam int SC = 3;
  localparam int PER  = 1 << W;
  localparam int HOLD = SP * PER;
  localparam int SWP  = PER * HOLD;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_out;
  logic [W-1:0] r2r_out;
  logic [W-1:0] duty;
  logic         sweep_active;
  logic         sweep_done;

  int checks = 0;
  int errors = 0;

  ramp_generator #(
    .WIDTH        (W),
    .STEP_PERIODS (SP),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .pwm_out           (pwm_out),
    .r2r_out           (r2r_out),
    .current_duty_cycle(duty),
    .sweep_active      (sweep_active),
    .sweep_done        (sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic en;
    int   duty;
    logic act;
    logic done;
    logic pwm;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // wait for SWEEP with a bound; returns cycles spent waiting
  task automatic wait_active(output int n);
    n = 0;
    while (!sweep_active && n < 60) begin
      step();
      n++;
    end
    check("sweep_start", int'(sweep_active), 1);
  endtask

  // run a full sweep from its first cycle, checking every cycle
  task automatic run_sweep(input string tag);
    int hi;
    int idx;
    int ep;
    hi = 0;
    for (int i = 0; i < SWP; i++) begin
      check({tag, "_active"}, int'(sweep_active), 1);
      check({tag, "_duty"}, int'(duty), i / HOLD);
      check({tag, "_r2r"}, int'(r2r_out), i / HOLD);
      check({tag, "_done_low"}, int'(sweep_done), 0);
      if (i == 0) begin
        ep = 0;
      end else begin
        idx = i - 1;
        ep  = ((idx % PER) < (idx / HOLD)) ? 1 : 0;
        if ((idx % HOLD) < PER) hi += int'(pwm_out);
        if ((idx % HOLD) == PER - 1) begin
          if ((idx / HOLD) == 0 || (idx / HOLD) == 5 || (idx / HOLD) == 15)
            check({tag, "_pwm_high_count"}, hi, idx / HOLD);
          hi = 0;
        end
      end
      check({tag, "_pwm"}, int'(pwm_out), ep);
      step();
    end
    check({tag, "_done_pulse"}, int'(sweep_done), 1);
    check({tag, "_end_active"}, int'(sweep_active), 0);
    check({tag, "_end_duty"}, int'(duty), 0);
    check({tag, "_end_pwm"}, int'(pwm_out), 0);
    step();
    check({tag, "_done_1cyc"}, int'(sweep_done), 0);
    check({tag, "_settle_active"}, int'(sweep_active), 0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      reset  = tbl[i].rst;
      enable = tbl[i].en;
      step();
      check("tbl_duty", int'(duty), tbl[i].duty);
      check("tbl_r2r", int'(r2r_out), tbl[i].duty);
      check("tbl_active", int'(sweep_active), int'(tbl[i].act));
      check("tbl_done", int'(sweep_done), int'(tbl[i].done));
      check("tbl_pwm", int'(pwm_out), int'(tbl[i].pwm));
    end

    // full sweep after minimum settle
    wait_active(n);
    check("settle_min", (n >= SC - 1) ? 1 : 0, 1);
    run_sweep("sweep1");

    // abort at duty 7
    wait_active(n);
    check("resettle_min", (n >= SC - 1) ? 1 : 0, 1);
    repeat (7 * HOLD + 3) step();
    check("abort_pre_duty", int'(duty), 7);
    enable = 1'b0;
    step();
    check("abort_active", int'(sweep_active), 0);
    check("abort_duty", int'(duty), 0);
    check("abort_r2r", int'(r2r_out), 0);
    check("abort_done", int'(sweep_done), 0);
    step();
    check("abort_pwm", int'(pwm_out), 0);
    for (int k = 0; k < 40; k++) begin
      check("idle_done", int'(sweep_done), 0);
      check("idle_active", int'(sweep_active), 0);
      step();
    end

    // abort on the final-step wrap
    enable = 1'b1;
    wait_active(n);
    repeat (SWP - 1) step();
    check("final_pre_duty", int'(duty), 15);
    check("final_pre_active", int'(sweep_active), 1);
    enable = 1'b0;
    step();
    check("final_abort_done", int'(sweep_done), 0);
    check("final_abort_active", int'(sweep_active), 0);
    check("final_abort_duty", int'(duty), 0);
    step();
    check("final_abort_done2", int'(sweep_done), 0);

    // reset mid-sweep at duty 9
    enable = 1'b1;
    wait_active(n);
    repeat (9 * HOLD + 5) step();
    check("rst_pre_duty", int'(duty), 9);
    reset = 1'b1;
    step();
    check("rst_duty", int'(duty), 0);
    check("rst_r2r", int'(r2r_out), 0);
    check("rst_active", int'(sweep_active), 0);
    check("rst_done", int'(sweep_done), 0);
    check("rst_pwm", int'(pwm_out), 0);
    reset = 1'b0;
    wait_active(n);
    check("post_rst_settle", (n >= SC) ? 1 : 0, 1);
    run_sweep("sweep2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
